// File: rtl/result_link_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : result_link_pkg
//  Purpose : Shared definitions for the result-memory framed byte link.
//  Rev     : 1.0  initial release
// ============================================================================
package result_link_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_HDR     = 3'd1;
  localparam state_t ST_LEN     = 3'd2;
  localparam state_t ST_RD_REQ  = 3'd3;
  localparam state_t ST_RD_WAIT = 3'd4;
  localparam state_t ST_DATA    = 3'd5;
  localparam state_t ST_CSUM    = 3'd6;

  // Frame start marker, also used by the host-side parser.
  localparam logic [7:0] C_HEADER_BYTE = 8'hA5;

  localparam int C_MEM_RD_LATENCY = 1;

endpackage
`default_nettype wire

// File: rtl/start_edge_det.sv
`default_nettype none
// ============================================================================
//  Module  : start_edge_det
//  Purpose : Registered rising-edge detector for level control inputs.
//  Rev     : 1.0  initial release
// ============================================================================
module start_edge_det (
  input  logic clk,
  input  logic reset_n,
  input  logic level_i,
  output logic pulse_o
);

  logic level_q;
  logic pulse_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      level_q <= level_i;
      pulse_q <= level_i & ~level_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule
`default_nettype wire

// File: rtl/result_mem_reader.sv
`default_nettype none
// ============================================================================
//  Module  : result_mem_reader
//  Purpose : Reads pass counters from result memory and streams them as a
//            framed byte sequence (header, length, data, checksum).
//  Rev     : 1.0  initial release
// ============================================================================
module result_mem_reader
  import result_link_pkg::*;
#(
  parameter int         ADDR_WIDTH  = 13,
  parameter int         DATA_WIDTH  = 8,
  parameter int         BASE_ADDR   = 1,
  parameter int         NUM_ENTRIES = 8,
  parameter logic [7:0] HEADER_BYTE = C_HEADER_BYTE
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  frame_done
);

  localparam logic [7:0] LEN_BYTE = 8'(NUM_ENTRIES);
  localparam logic [7:0] LAST_IDX = 8'(NUM_ENTRIES - 1);

  state_t                  state_q, state_d;
  logic                    busy_q, busy_d;
  logic [7:0]              checksum_q, checksum_d;
  logic [7:0]              index_q, index_d;
  logic [7:0]              data_q, data_d;
  logic                    start_pulse;
  logic [ADDR_WIDTH-1:0]   rd_addr;

  start_edge_det u_start_edge_det (
    .clk     (clk),
    .reset_n (reset_n),
    .level_i (start),
    .pulse_o (start_pulse)
  );

  // Address arithmetic wraps naturally at the ADDR_WIDTH boundary.
  assign rd_addr = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(index_q);

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    checksum_d = checksum_q;
    index_d    = index_q;
    data_d     = data_q;
    case (state_q)
      ST_IDLE: begin
        if (start_pulse) begin
          state_d    = ST_HDR;
          busy_d     = 1'b1;
          checksum_d = 8'h00;
          index_d    = 8'h00;
        end
      end
      ST_HDR: begin
        if (tx_ready) state_d = ST_LEN;
      end
      ST_LEN: begin
        if (tx_ready) begin
          checksum_d = LEN_BYTE;
          state_d    = ST_RD_REQ;
        end
      end
      ST_RD_REQ: begin
        state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        data_d  = mem_dout[7:0];
        state_d = ST_DATA;
      end
      ST_DATA: begin
        if (tx_ready) begin
          checksum_d = checksum_q + data_q;
          if (index_q == LAST_IDX) begin
            state_d = ST_CSUM;
          end else begin
            index_d = index_q + 8'd1;
            state_d = ST_RD_REQ;
          end
        end
      end
      ST_CSUM: begin
        if (tx_ready) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      checksum_q <= 8'h00;
      index_q    <= 8'h00;
      data_q     <= 8'h00;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      checksum_q <= checksum_d;
      index_q    <= index_d;
      data_q     <= data_d;
    end
  end

  // Outputs decode straight from state so an async reset clears them at once.
  always_comb begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    case (state_q)
      ST_HDR:  begin tx_valid = 1'b1; tx_data = HEADER_BYTE; end
      ST_LEN:  begin tx_valid = 1'b1; tx_data = LEN_BYTE;    end
      ST_DATA: begin tx_valid = 1'b1; tx_data = data_q;      end
      ST_CSUM: begin tx_valid = 1'b1; tx_data = checksum_q;  end
      default: begin tx_valid = 1'b0; tx_data = 8'h00;       end
    endcase
  end

  assign mem_re     = (state_q == ST_RD_REQ);
  assign mem_raddr  = mem_re ? rd_addr : '0;
  assign frame_done = (state_q == ST_CSUM) && tx_ready;
  assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_result_mem_reader.sv
`default_nettype none
// ============================================================================
//  Module  : tb_result_mem_reader
//  Purpose : Randomized self-checking bench; instance 0 uses default
//            parameters, instance 1 reads across the address wrap.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_result_mem_reader;

  localparam int AW    = 13;
  localparam int NI    = 2;
  localparam int MSIZE = 8192;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset_n;
  logic            tx_ready;
  logic            rand_ready;
  logic            start_s    [NI];
  logic            re         [NI];
  logic [AW-1:0]   raddr      [NI];
  logic [7:0]      dout       [NI];
  logic [7:0]      tx_data    [NI];
  logic            tx_valid   [NI];
  logic            busy       [NI];
  logic            frame_done [NI];
  logic [7:0]      mem        [0:MSIZE-1];

  int checks   = 0;
  int failures = 0;
  int done_cnt [NI];
  int rd_cnt   [NI];
  int acc_cnt  [NI];

  logic [7:0]    exp_q  [NI][$];
  logic [AW-1:0] addr_q [NI][$];
  logic [7:0]    rx_log [NI][$];

  result_mem_reader u_dut0 (
    .clk(clk), .reset_n(reset_n), .start(start_s[0]),
    .mem_re(re[0]), .mem_raddr(raddr[0]), .mem_dout(dout[0]),
    .tx_data(tx_data[0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready),
    .busy(busy[0]), .frame_done(frame_done[0])
  );

  result_mem_reader #(.BASE_ADDR(8190), .NUM_ENTRIES(4)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .start(start_s[1]),
    .mem_re(re[1]), .mem_raddr(raddr[1]), .mem_dout(dout[1]),
    .tx_data(tx_data[1]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready),
    .busy(busy[1]), .frame_done(frame_done[1])
  );

  function automatic int base_of(int k);
    return (k == 0) ? 1 : 8190;
  endfunction

  function automatic int num_of(int k);
    return (k == 0) ? 8 : 4;
  endfunction

  // One-cycle read latency; the bus carries junk whenever no read was issued.
  always @(posedge clk) begin
    for (int k = 0; k < NI; k++)
      dout[k] <= re[k] ? mem[raddr[k]] : 8'($urandom);
  end

  task automatic chk(string name, int k, int got, int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s inst=%0d got=0x%0h want=0x%0h t=%0t", name, k, got, want, $time);
    end
  endtask

  task automatic fail_now(string name, int k, int got);
    checks++;
    failures++;
    $display("FAIL %s inst=%0d got=0x%0h want=none t=%0t", name, k, got, $time);
  endtask

  // Expected frame from the framing rules: header, length, data, sum(len+data).
  task automatic build_model(int k);
    int n;
    int b;
    int a;
    logic [7:0] sum;
    n = num_of(k);
    b = base_of(k);
    exp_q[k].push_back(8'hA5);
    exp_q[k].push_back(8'(n));
    sum = 8'(n);
    for (int i = 0; i < n; i++) begin
      a = (b + i) % MSIZE;
      addr_q[k].push_back(AW'(a));
      exp_q[k].push_back(mem[a]);
      sum = sum + mem[a];
    end
    exp_q[k].push_back(sum);
  endtask

  // Compare process: handshake bytes, read addresses, stall stability, done pulse.
  logic       prev_v [NI];
  logic [7:0] prev_d [NI];
  logic       prev_r;
  initial begin
    for (int k = 0; k < NI; k++) begin
      prev_v[k] = 1'b0; prev_d[k] = 8'h00;
      done_cnt[k] = 0; rd_cnt[k] = 0; acc_cnt[k] = 0;
    end
    prev_r = 1'b1;
    forever begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        if (!reset_n) begin
          prev_v[k] = 1'b0;
        end else begin
          if (prev_v[k] && !prev_r) begin
            chk("stall_valid", k, int'(tx_valid[k]), 1);
            chk("stall_data", k, int'(tx_data[k]), int'(prev_d[k]));
          end
          if (frame_done[k]) begin
            chk("done_on_csum_accept", k,
                int'(tx_valid[k] && tx_ready && exp_q[k].size() == 1), 1);
            done_cnt[k]++;
          end
          if (tx_valid[k] && tx_ready) begin
            if (exp_q[k].size() == 0) fail_now("unexpected_byte", k, int'(tx_data[k]));
            else chk("stream_byte", k, int'(tx_data[k]), int'(exp_q[k].pop_front()));
            rx_log[k].push_back(tx_data[k]);
            acc_cnt[k]++;
          end
          if (re[k]) begin
            if (addr_q[k].size() == 0) fail_now("unexpected_read", k, int'(raddr[k]));
            else chk("read_addr", k, int'(raddr[k]), int'(addr_q[k].pop_front()));
            rd_cnt[k]++;
          end
          prev_v[k] = tx_valid[k];
          prev_d[k] = tx_data[k];
        end
      end
      prev_r = tx_ready;
    end
  end

  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic wait_done(int k, int target, int budget, string name);
    int c;
    c = 0;
    while (done_cnt[k] < target && c < budget) begin
      @(posedge clk);
      c++;
    end
    #1;
    chk(name, k, done_cnt[k], target);
  endtask

  task automatic frame_post(int k, int r0, string tag);
    chk({tag, "_busy_low"}, k, int'(busy[k]), 0);
    chk({tag, "_read_count"}, k, rd_cnt[k] - r0, num_of(k));
    chk({tag, "_model_drained"}, k, exp_q[k].size(), 0);
  endtask

  task automatic run_frame(int k, string tag);
    int d0;
    int r0;
    d0 = done_cnt[k];
    r0 = rd_cnt[k];
    rx_log[k].delete();
    build_model(k);
    @(posedge clk); #1 start_s[k] = 1'b1;
    repeat (2) @(posedge clk);
    #1 start_s[k] = 1'b0;
    wait_done(k, d0 + 1, 600, {tag, "_done"});
    frame_post(k, r0, tag);
  endtask

  task automatic fill_random(int k);
    for (int i = 0; i < num_of(k); i++) mem[(base_of(k) + i) % MSIZE] = 8'($urandom);
  endtask

  initial begin
    int d0;
    int r0;
    int a0;
    int c;
    reset_n    = 1'b0;
    rand_ready = 1'b0;
    for (int k = 0; k < NI; k++) start_s[k] = 1'b0;
    for (int i = 0; i < MSIZE; i++) mem[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_valid", 0, int'(tx_valid[0]), 0);
    chk("rst_tx_data", 0, int'(tx_data[0]), 0);
    chk("rst_busy", 0, int'(busy[0]), 0);
    chk("rst_mem_re", 0, int'(re[0]), 0);
    chk("rst_mem_raddr", 0, int'(raddr[0]), 0);
    chk("rst_frame_done", 0, int'(frame_done[0]), 0);
    @(posedge clk); #1 reset_n = 1'b1;

    // Counters 1..8, ready always high, with header latency pinned.
    for (int i = 1; i <= 8; i++) mem[i] = 8'(i);
    d0 = done_cnt[0]; r0 = rd_cnt[0];
    rx_log[0].delete();
    build_model(0);
    @(posedge clk); #1 start_s[0] = 1'b1;
    @(posedge clk); #1;
    chk("hdr_not_yet_valid", 0, int'(tx_valid[0]), 0);
    @(posedge clk); #1;
    chk("hdr_valid_latency", 0, int'(tx_valid[0]), 1);
    chk("hdr_byte", 0, int'(tx_data[0]), 8'hA5);
    chk("busy_in_frame", 0, int'(busy[0]), 1);
    start_s[0] = 1'b0;
    wait_done(0, d0 + 1, 200, "basic_done");
    frame_post(0, r0, "basic");
    chk("basic_len", 0, rx_log[0].size(), 11);
    if (rx_log[0].size() == 11) begin
      chk("basic_len_byte", 0, int'(rx_log[0][1]), 8'h08);
      chk("basic_data4", 0, int'(rx_log[0][5]), 8'h04);
      chk("basic_csum", 0, int'(rx_log[0][10]), 8'h2C);
    end

    // Same data under random backpressure.
    rand_ready = 1'b1;
    run_frame(0, "stall");
    chk("stall_csum", 0, int'(rx_log[0][rx_log[0].size()-1]), 8'h2C);

    // All-FF counters wrap the checksum to zero.
    for (int i = 1; i <= 8; i++) mem[i] = 8'hFF;
    run_frame(0, "allff");
    chk("allff_csum", 0, int'(rx_log[0][rx_log[0].size()-1]), 8'h00);

    // Long start level plus a second edge mid-frame -> one frame only.
    rand_ready = 1'b0;
    fill_random(0);
    d0 = done_cnt[0]; r0 = rd_cnt[0];
    build_model(0);
    @(posedge clk); #1 start_s[0] = 1'b1;
    repeat (6) @(posedge clk);
    #1 start_s[0] = 1'b0;
    @(posedge clk); #1 start_s[0] = 1'b1;
    repeat (490) @(posedge clk);
    #1 start_s[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("held_start_one_frame", 0, done_cnt[0] - d0, 1);
    frame_post(0, r0, "held");

    // Reset while the 4th data byte is on offer, then a clean frame.
    rand_ready = 1'b1;
    fill_random(0);
    d0 = done_cnt[0];
    a0 = acc_cnt[0];
    build_model(0);
    @(posedge clk); #1 start_s[0] = 1'b1;
    @(posedge clk); #1 start_s[0] = 1'b0;
    c = 0;
    do begin
      @(posedge clk); #2;
      c++;
    end while (!(tx_valid[0] && acc_cnt[0] - a0 == 5) && c < 400);
    chk("reach_4th_data", 0, int'(tx_valid[0] && acc_cnt[0] - a0 == 5), 1);
    reset_n = 1'b0;
    exp_q[0].delete();
    addr_q[0].delete();
    #1;
    chk("async_rst_tx_valid", 0, int'(tx_valid[0]), 0);
    chk("async_rst_tx_data", 0, int'(tx_data[0]), 0);
    chk("async_rst_busy", 0, int'(busy[0]), 0);
    chk("async_rst_mem_re", 0, int'(re[0]), 0);
    chk("async_rst_frame_done", 0, int'(frame_done[0]), 0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    chk("abandoned_no_done", 0, done_cnt[0] - d0, 0);
    fill_random(0);
    run_frame(0, "after_reset");
    chk("after_reset_len", 0, rx_log[0].size(), 11);

    // Address wrap on the second instance.
    mem[8190] = 8'h11; mem[8191] = 8'h22; mem[0] = 8'h33; mem[1] = 8'h44;
    run_frame(1, "wrap");
    chk("wrap_len", 1, rx_log[1].size(), 7);
    chk("wrap_csum", 1, int'(rx_log[1][rx_log[1].size()-1]), 8'hAE);
    for (int i = 0; i < 3; i++) begin
      mem[8190] = 8'($urandom); mem[8191] = 8'($urandom);
      mem[0] = 8'($urandom); mem[1] = 8'($urandom);
      run_frame(1, "wrap_rand");
    end

    // A few more random frames on the default instance.
    for (int i = 0; i < 3; i++) begin
      fill_random(0);
      run_frame(0, "rand");
    end

    repeat (4) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
